ty_axis_vect_tx: RTL and testbench



---
 rtl/ty_axis_vect_tx.sv | 149 ++++++++++++++
 tb/tb_ty_axis_vect_tx.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ty_axis_vect_tx.sv
// Dual-channel AXI4-Stream vector transmitter: packs scalar words into vectors,
// buffers them in a 2-entry FIFO per channel and streams C_LEN vectors per run.
module ty_axis_vect_tx #(
    parameter int unsigned C_DATA_WIDTH   = 128,
    parameter int unsigned C_WORD_WIDTH   = 32,
    parameter int unsigned C_NUM_CHANNELS = 2,
    parameter int unsigned C_LEN          = 1024
) (
    input  logic                                         aclk,
    input  logic                                         areset,
    input  logic                                         start,
    output logic                                         busy,
    output logic                                         done,
    input  logic [C_NUM_CHANNELS-1:0]                    w_tvalid,
    input  logic [C_NUM_CHANNELS-1:0][C_WORD_WIDTH-1:0]  w_tdata,
    output logic [C_NUM_CHANNELS-1:0]                    w_tready,
    output logic [C_NUM_CHANNELS-1:0]                    m_tvalid,
    output logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  m_tdata,
    input  logic [C_NUM_CHANNELS-1:0]                    m_tready
);

    localparam int unsigned LANES     = C_DATA_WIDTH / C_WORD_WIDTH;
    localparam int unsigned LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned VEC_W     = $clog2(C_LEN + 1);
    localparam int unsigned LAST_LSB  = (LANES - 1) * C_WORD_WIDTH;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [VEC_W-1:0]  VEC_MAX   = VEC_W'(C_LEN);
    localparam logic [VEC_W-1:0]  VEC_LAST  = VEC_W'(C_LEN - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e r_state;
    state_e w_state_next;
    logic   w_run_start;

    logic [C_NUM_CHANNELS-1:0] w_push;
    logic [C_NUM_CHANNELS-1:0] w_pop;
    logic [C_NUM_CHANNELS-1:0] w_len_reached;
    logic [C_NUM_CHANNELS-1:0] w_drained;

    assign w_run_start = (r_state == StIdle) && start;

    for (genvar c = 0; c < C_NUM_CHANNELS; c++) begin : g_ch
        logic [LANE_W-1:0]       r_lane;
        logic [VEC_W-1:0]        r_vec;
        logic [C_DATA_WIDTH-1:0] r_pack;
        logic [C_DATA_WIDTH-1:0] r_mem [2];
        logic                    r_wr_ptr;
        logic                    r_rd_ptr;
        logic [1:0]              r_cnt;
        logic                    w_last;
        logic                    w_ready;
        logic                    w_accept;
        logic [C_DATA_WIDTH-1:0] w_vec;

        assign w_last   = (r_lane == LAST_LANE);
        // Ready depends only on registered state, so no path from m_tready.
        assign w_ready  = (r_state == StRun) && (r_vec < VEC_MAX)
                          && (!w_last || (r_cnt < 2'd2));
        assign w_accept = w_tvalid[c] && w_ready;
        assign w_push[c] = w_accept && w_last;
        assign w_pop[c]  = (r_cnt != 2'd0) && m_tready[c];

        // Counts the push happening this cycle so DRAIN is entered right after it.
        assign w_len_reached[c] = (r_vec == VEC_MAX) || (w_push[c] && (r_vec == VEC_LAST));
        // Empty now, or emptied by the pop of this cycle.
        assign w_drained[c] = (r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop[c]);

        // Completed vector: pack register with the current word in the top lane.
        always_comb begin
            w_vec = r_pack;
            w_vec[LAST_LSB +: C_WORD_WIDTH] = w_tdata[c];
        end

        // Lane/vector counters and pack register; cleared when a run is launched.
        always_ff @(posedge aclk or negedge areset) begin
            if (!areset) begin
                r_lane <= '0;
                r_vec  <= '0;
                r_pack <= '0;
            end else if (w_run_start) begin
                r_lane <= '0;
                r_vec  <= '0;
                r_pack <= '0;
            end else if (w_accept) begin
                r_pack[r_lane*C_WORD_WIDTH +: C_WORD_WIDTH] <= w_tdata[c];
                if (w_last) begin
                    r_lane <= '0;
                    r_vec  <= r_vec + 1'b1;
                end else begin
                    r_lane <= r_lane + 1'b1;
                end
            end
        end

        // Two-entry vector FIFO; head entry drives m_tdata directly.
        always_ff @(posedge aclk or negedge areset) begin
            if (!areset) begin
                r_mem[0] <= '0;
                r_mem[1] <= '0;
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
                r_cnt    <= 2'd0;
            end else begin
                if (w_push[c]) begin
                    r_mem[r_wr_ptr] <= w_vec;
                    r_wr_ptr        <= ~r_wr_ptr;
                end
                if (w_pop[c]) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                case ({w_push[c], w_pop[c]})
                    2'b10:   r_cnt <= r_cnt + 1'b1;
                    2'b01:   r_cnt <= r_cnt - 1'b1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        assign w_tready[c] = w_ready;
        assign m_tvalid[c] = (r_cnt != 2'd0);
        assign m_tdata[c]  = r_mem[r_rd_ptr];
    end

    // Run-control state register.
    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Run-control next state; start is only honoured in IDLE.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_next = StRun;
            StRun:   if (&w_len_reached) w_state_next = StDrain;
            StDrain: if (&w_drained) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    assign busy = (r_state != StIdle);
    assign done = (r_state == StDone);

endmodule

// File: tb/tb_ty_axis_vect_tx.sv
// Scoreboard bench for ty_axis_vect_tx with C_LEN=4 and four 32-bit lanes.
module tb_ty_axis_vect_tx;

    localparam int unsigned DW  = 128;
    localparam int unsigned WW  = 32;
    localparam int unsigned NC  = 2;
    localparam int unsigned LEN = 4;

    logic                   aclk;
    logic                   areset;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic [NC-1:0]          w_tvalid;
    logic [NC-1:0][WW-1:0]  w_tdata;
    logic [NC-1:0]          w_tready;
    logic [NC-1:0]          m_tvalid;
    logic [NC-1:0][DW-1:0]  m_tdata;
    logic [NC-1:0]          m_tready;

    ty_axis_vect_tx #(
        .C_DATA_WIDTH   (DW),
        .C_WORD_WIDTH   (WW),
        .C_NUM_CHANNELS (NC),
        .C_LEN          (LEN)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .w_tvalid (w_tvalid),
        .w_tdata  (w_tdata),
        .w_tready (w_tready),
        .m_tvalid (m_tvalid),
        .m_tdata  (m_tdata),
        .m_tready (m_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    logic [DW-1:0] got_q0[$];
    logic [DW-1:0] got_q1[$];
    int            acc[2];
    int            done_cnt = 0;
    logic [1:0]    prev_stall = '0;
    logic [1:0][DW-1:0] prev_data;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on every accepted vector, checks hold stability.
    initial begin
        acc[0] = 0;
        acc[1] = 0;
    end
    always @(negedge aclk) begin
        if (!areset) begin
            exp_q0.delete();
            exp_q1.delete();
            prev_stall = '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                logic [DW-1:0] e;
                bit ok;
                if (prev_stall[c]) begin
                    chk($sformatf("hold valid ch%0d", c), m_tvalid[c], 1);
                    chk($sformatf("hold data ch%0d", c), m_tdata[c], prev_data[c]);
                end
                if (m_tvalid[c] && m_tready[c]) begin
                    e = '0;
                    if (c == 0) begin
                        ok = (exp_q0.size() > 0);
                        if (ok) e = exp_q0.pop_front();
                        got_q0.push_back(m_tdata[c]);
                    end else begin
                        ok = (exp_q1.size() > 0);
                        if (ok) e = exp_q1.pop_front();
                        got_q1.push_back(m_tdata[c]);
                    end
                    if (!ok) chk($sformatf("unexpected vector ch%0d", c), m_tvalid[c], 0);
                    else chk($sformatf("vector ch%0d", c), m_tdata[c], e);
                end
                if (w_tvalid[c] && w_tready[c]) acc[c]++;
                prev_stall[c] = m_tvalid[c] & ~m_tready[c];
                prev_data[c]  = m_tdata[c];
            end
            if (done) done_cnt++;
        end
    end

    // Streams n words base..base+n-1 on channel c; queues each expected vector.
    task automatic send(input int c, input int base, input int n, input bit hold);
        logic [DW-1:0] v;
        int t;
        v = '0;
        for (int i = 0; i < n; i++) begin
            w_tvalid[c] = 1'b1;
            w_tdata[c]  = WW'(base + i);
            t = 0;
            @(negedge aclk);
            while (!w_tready[c] && t < 500) begin
                @(negedge aclk);
                t++;
            end
            if (t >= 500) begin
                chk($sformatf("accept timeout ch%0d", c), w_tready[c], 1);
                w_tvalid[c] = 1'b0;
                return;
            end
            v[(i % 4)*WW +: WW] = WW'(base + i);
            if (i % 4 == 3) begin
                if (c == 0) exp_q0.push_back(v);
                else exp_q1.push_back(v);
            end
            @(posedge aclk);
            #1;
        end
        w_tvalid[c] = hold;
        w_tdata[c]  = hold ? 32'hDEAD_BEEF : 32'h0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge aclk);
        #1;
        start = 1'b0;
        chk("busy after start", busy, 1);
    endtask

    task automatic wait_done();
        int t = 0;
        do begin
            @(negedge aclk);
            t++;
        end while (done !== 1'b1 && t < 1000);
        chk("done pulse seen", done, 1);
        chk("busy during done", busy, 1);
        chk("fifos empty at done", m_tvalid, 0);
        @(negedge aclk);
        chk("idle after done", {busy, done}, 0);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int a0, a1, g0, g1, d0, t;

        // Reset with all inputs active.
        areset   = 1'b0;
        start    = 1'b1;
        w_tvalid = 2'b11;
        w_tdata  = {32'h1234_5678, 32'h9ABC_DEF0};
        m_tready = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("reset status outputs", {busy, done, w_tready, m_tvalid}, 0);
            chk("reset m_tdata", m_tdata[0] | m_tdata[1], 0);
        end
        @(posedge aclk);
        #1;
        areset   = 1'b1;
        start    = 1'b0;
        w_tvalid = 2'b00;
        w_tdata  = '0;
        @(posedge aclk);
        #1;
        chk("idle after release", {busy, done, w_tready, m_tvalid}, 0);

        // Basic run.
        g0 = got_q0.size(); g1 = got_q1.size(); d0 = done_cnt;
        pulse_start();
        fork
            send(0, 0, 16, 1'b0);
            send(1, 100, 16, 1'b0);
        join
        wait_done();
        chk("basic ch0 count", got_q0.size() - g0, 4);
        chk("basic ch1 count", got_q1.size() - g1, 4);
        chk("basic done count", done_cnt - d0, 1);
        if (got_q0.size() > g0)
            chk("basic first ch0", got_q0[g0], 128'h00000003_00000002_00000001_00000000);
        if (got_q1.size() >= g1 + 4)
            chk("basic last ch1", got_q1[g1+3], 128'h00000073_00000072_00000071_00000070);
        chk("basic scoreboard drained", exp_q0.size() + exp_q1.size(), 0);

        // Backpressure on ch1 for 20 cycles.
        m_tready = 2'b01;
        g0 = got_q0.size(); g1 = got_q1.size(); d0 = done_cnt;
        a0 = acc[0]; a1 = acc[1];
        pulse_start();
        fork
            send(0, 200, 16, 1'b0);
            send(1, 300, 16, 1'b0);
            begin
                repeat (20) @(posedge aclk);
                #1;
                chk("bp ch1 accepted", acc[1] - a1, 11);
                chk("bp ch1 ready low", w_tready[1], 0);
                chk("bp ch0 unaffected", acc[0] - a0, 16);
                chk("bp ch1 nothing out", got_q1.size() - g1, 0);
                m_tready[1] = 1'b1;
                @(posedge aclk);
                #1;
                chk("bp ch1 ready after pop", w_tready[1], 1);
            end
        join
        wait_done();
        chk("bp ch0 count", got_q0.size() - g0, 4);
        chk("bp ch1 count", got_q1.size() - g1, 4);
        chk("bp done count", done_cnt - d0, 1);
        if (got_q1.size() > g1)
            chk("bp first ch1", got_q1[g1], 128'h0000012F_0000012E_0000012D_0000012C);

        // Over-supply: valid held high after the last word.
        g0 = got_q0.size(); g1 = got_q1.size(); a0 = acc[0]; a1 = acc[1];
        pulse_start();
        fork
            send(0, 700, 16, 1'b1);
            send(1, 800, 16, 1'b1);
        join
        @(negedge aclk);
        chk("oversupply ready low", w_tready, 0);
        wait_done();
        chk("oversupply ch0 words", acc[0] - a0, 16);
        chk("oversupply ch1 words", acc[1] - a1, 16);
        chk("oversupply ch0 count", got_q0.size() - g0, 4);
        chk("oversupply ch1 count", got_q1.size() - g1, 4);
        w_tvalid = 2'b00;
        w_tdata  = '0;

        // Mid-run reset with a vector held in the ch0 FIFO.
        m_tready = 2'b10;
        pulse_start();
        send(0, 400, 6, 1'b0);
        chk("vector held before reset", m_tvalid[0], 1);
        areset = 1'b0;
        #1;
        chk("reset clears m_tvalid", m_tvalid, 0);
        chk("reset clears status", {busy, done, w_tready}, 0);
        @(posedge aclk);
        @(posedge aclk);
        #1;
        areset   = 1'b1;
        m_tready = 2'b11;
        @(posedge aclk);
        #1;
        g0 = got_q0.size(); g1 = got_q1.size();
        pulse_start();
        fork
            send(0, 500, 16, 1'b0);
            send(1, 600, 16, 1'b0);
        join
        wait_done();
        chk("post-reset ch0 count", got_q0.size() - g0, 4);
        if (got_q0.size() > g0)
            chk("post-reset first ch0", got_q0[g0], 128'h000001F7_000001F6_000001F5_000001F4);

        // Start while busy, in RUN and in DRAIN.
        g0 = got_q0.size(); g1 = got_q1.size(); d0 = done_cnt;
        a0 = acc[0]; a1 = acc[1];
        pulse_start();
        fork
            send(0, 900, 16, 1'b0);
            send(1, 1000, 16, 1'b0);
            begin
                repeat (3) @(posedge aclk);
                #1;
                start = 1'b1;
                @(posedge aclk);
                #1;
                start = 1'b0;
                chk("busy after start in run", busy, 1);
                t = 0;
                while (got_q0.size() - g0 < 2 && t < 200) begin
                    @(posedge aclk);
                    #1;
                    t++;
                end
                chk("two ch0 vectors before stall", got_q0.size() - g0, 2);
                m_tready[0] = 1'b0;
                t = 0;
                while ((acc[0] - a0 < 16 || acc[1] - a1 < 16) && t < 200) begin
                    @(posedge aclk);
                    #1;
                    t++;
                end
                chk("all words before drain", (acc[0] - a0) + (acc[1] - a1), 32);
                @(posedge aclk);
                #1;
                chk("drain holds ch0", m_tvalid[0], 1);
                start = 1'b1;
                @(posedge aclk);
                #1;
                start = 1'b0;
                repeat (3) @(posedge aclk);
                #1;
                chk("still draining", {busy, done, m_tvalid[0]}, 3'b101);
                m_tready[0] = 1'b1;
            end
        join
        wait_done();
        chk("busy-start ch0 count", got_q0.size() - g0, 4);
        chk("busy-start ch1 count", got_q1.size() - g1, 4);
        chk("busy-start done count", done_cnt - d0, 1);
        repeat (3) @(posedge aclk);
        #1;
        chk("stays idle", {busy, done, m_tvalid}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
